// File: rtl/irq_priority_encoder.sv
// ============================================================================
// irq_priority_encoder
// ----------------------------------------------------------------------------
// Captures up to 16 request lines into a pending register, applies a per-line
// mask, and presents the lowest-numbered unmasked pending line as a 4-bit ID
// through a valid/ack handshake. A programmable hold-off gap follows every
// accepted ID, so the control unit always sees a quiet period between IDs.
//
// Parameters
//   EDGE_MODE      : 1 = rising edges set sticky pending bits (cleared by ack)
//                    0 = pending mirrors the registered request lines
//   HOLDOFF_CYCLES : idle cycles forced after each ack (0..7)
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   rst        in   asynchronous active-high reset
//   req[15:0]  in   request lines, bit 0 is highest priority
//   mask[15:0] in   1 = line masked (still latched, never presented)
//   ack        in   accepts the presented ID; only honoured while irq_valid=1
//   irq_valid  out  registered, an ID is being presented
//   irq_id     out  registered index of the presented line
//   pending    out  registered pending bits (mask not applied)
// ============================================================================
module irq_priority_encoder #(
    parameter int EDGE_MODE      = 1,
    parameter int HOLDOFF_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic [15:0] mask,
    input  logic        ack,
    output logic        irq_valid,
    output logic [3:0]  irq_id,
    output logic [15:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Value loaded into the hold-off counter on entry; the state is skipped
    // entirely when no hold-off is configured, so the guard only avoids a
    // negative constant.
    localparam logic [2:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? 3'(HOLDOFF_CYCLES - 1) : 3'd0;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_s;
    logic [15:0] req_q_r;
    logic [15:0] pending_r;
    logic [15:0] pending_s;
    logic [15:0] cand_s;
    logic [15:0] ack_clr_s;
    logic        ack_take_s;
    logic        irq_valid_r;
    logic        irq_valid_s;
    logic [3:0]  irq_id_r;
    logic [3:0]  irq_id_s;

    // Index of the lowest set bit; the descending loop lets the lowest index
    // overwrite any higher one. Returns 0 for an all-zero vector.
    function automatic logic [3:0] lowest_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign cand_s    = pending_r & ~mask;
    assign irq_valid = irq_valid_r;
    assign irq_id    = irq_id_r;
    assign pending   = pending_r;

    // Ack is only meaningful while an ID is on the bus.
    always_comb begin
        ack_take_s = 1'b0;
        ack_clr_s  = 16'd0;
        if ((state_r == ST_PRESENT) && ack) begin
            ack_take_s = 1'b1;
            ack_clr_s  = 16'd1 << irq_id_r;
        end else begin
            ack_take_s = 1'b0;
            ack_clr_s  = 16'd0;
        end
    end

    // Next pending vector: new rising edges are OR-ed in after the ack clear,
    // so a simultaneous set and clear leaves the bit set.
    always_comb begin
        pending_s = pending_r;
        if (EDGE_MODE != 0) begin
            pending_s = (pending_r & ~ack_clr_s) | (req & ~req_q_r);
        end else begin
            pending_s = req;
        end
    end

    // Handshake FSM: next state, hold-off counter and presented ID/valid.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        irq_valid_s = irq_valid_r;
        irq_id_s    = irq_id_r;
        case (state_r)
            ST_IDLE: begin
                if (cand_s != 16'd0) begin
                    state_s     = ST_PRESENT;
                    irq_valid_s = 1'b1;
                    irq_id_s    = lowest_index(cand_s);
                end else begin
                    state_s     = ST_IDLE;
                    irq_valid_s = 1'b0;
                end
            end
            ST_PRESENT: begin
                // No preemption: the latched ID stays until it is acked.
                if (ack_take_s) begin
                    irq_valid_s = 1'b0;
                    if (HOLDOFF_CYCLES == 0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_HOLDOFF;
                        cnt_s   = HOLD_LOAD;
                    end
                end else begin
                    irq_valid_s = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                irq_valid_s = 1'b0;
                if (cnt_r == 3'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = 3'd0;
                irq_valid_s = 1'b0;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            req_q_r     <= 16'd0;
            pending_r   <= 16'd0;
            irq_valid_r <= 1'b0;
            irq_id_r    <= 4'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            req_q_r     <= req;
            pending_r   <= pending_s;
            irq_valid_r <= irq_valid_s;
            irq_id_r    <= irq_id_s;
        end
    end

endmodule

// File: tb/tb_irq_priority_encoder.sv
// ============================================================================
// tb_irq_priority_encoder
// Two instances: [0] edge mode with a 1-cycle hold-off, [1] level mode with a
// 3-cycle hold-off. A behavioural model of each runs alongside and is compared
// on every falling edge; directed sequences pin the model with literal values,
// then a randomized phase exercises both instances.
// ============================================================================
module tb_irq_priority_encoder;

    logic        clk;
    logic        rst;
    logic [15:0] req_a   [2];
    logic [15:0] mask_a  [2];
    logic        ack_a   [2];
    logic        valid_a [2];
    logic [3:0]  id_a    [2];
    logic [15:0] pend_a  [2];

    int cmp_cnt;
    int err_cnt;
    bit chk_en;

    // Model state
    logic [15:0] m_pend  [2];
    logic [15:0] m_prev  [2];
    logic        m_valid [2];
    logic [3:0]  m_id    [2];
    int          m_quiet [2];

    irq_priority_encoder #(.EDGE_MODE(1), .HOLDOFF_CYCLES(1)) u_edge (
        .clk(clk), .rst(rst), .req(req_a[0]), .mask(mask_a[0]), .ack(ack_a[0]),
        .irq_valid(valid_a[0]), .irq_id(id_a[0]), .pending(pend_a[0])
    );

    irq_priority_encoder #(.EDGE_MODE(0), .HOLDOFF_CYCLES(3)) u_lvl (
        .clk(clk), .rst(rst), .req(req_a[1]), .mask(mask_a[1]), .ack(ack_a[1]),
        .irq_valid(valid_a[1]), .irq_id(id_a[1]), .pending(pend_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_edge(input int k);
        return (k == 0);
    endfunction

    function automatic int hold_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [3:0] first_set(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Pending bits after this edge, straight from the capture rules.
    function automatic logic [15:0] next_pend(input int k);
        logic [15:0] r;
        if (!is_edge(k)) return req_a[k];
        r = m_pend[k];
        for (int i = 0; i < 16; i++) begin
            if (m_valid[k] && ack_a[k] && (int'(m_id[k]) == i)) r[i] = 1'b0;
            if (req_a[k][i] && !m_prev[k][i]) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Reference model: pending capture plus a cool-down count after each ack.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_pend[k]  <= 16'h0;
                m_prev[k]  <= 16'h0;
                m_valid[k] <= 1'b0;
                m_id[k]    <= 4'd0;
                m_quiet[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_pend[k] <= next_pend(k);
                m_prev[k] <= req_a[k];
                if (m_valid[k]) begin
                    if (ack_a[k]) begin
                        m_valid[k] <= 1'b0;
                        m_quiet[k] <= hold_of(k);
                    end
                end else if (m_quiet[k] > 0) begin
                    m_quiet[k] <= m_quiet[k] - 1;
                end else if ((m_pend[k] & ~mask_a[k]) != 16'h0) begin
                    m_valid[k] <= 1'b1;
                    m_id[k]    <= first_set(m_pend[k] & ~mask_a[k]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s [inst %0d] t=%0t: actual %h, required %h", nm, k, $time, act, exp);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("model_valid", k, 16'(valid_a[k]), 16'(m_valid[k]));
                chk("model_pending", k, pend_a[k], m_pend[k]);
                if (m_valid[k]) chk("model_id", k, 16'(id_a[k]), 16'(m_id[k]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input int k, input logic [15:0] bits);
        req_a[k] = bits;
        tick();
        req_a[k] = 16'h0;
    endtask

    task automatic do_ack(input int k);
        ack_a[k] = 1'b1;
        tick();
        ack_a[k] = 1'b0;
    endtask

    // Counts falling edges until irq_valid is seen; a timeout is a failure.
    task automatic wait_valid(input int k, input int budget, output int n);
        n = 0;
        while ((valid_a[k] !== 1'b1) && (n < budget)) begin
            tick();
            n++;
        end
        if (valid_a[k] !== 1'b1) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL wait_valid [inst %0d]: actual timeout after %0d cycles, required irq_valid=1", k, n);
        end
    endtask

    initial begin
        int n;
        cmp_cnt = 0;
        err_cnt = 0;
        chk_en  = 1'b0;
        rst     = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_a[k]  = 16'h0;
            mask_a[k] = 16'h0;
            ack_a[k]  = 1'b0;
        end
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("reset_valid", 0, 16'(valid_a[0]), 16'h0);
        chk("reset_id", 0, 16'(id_a[0]), 16'h0);
        chk("reset_pending", 0, pend_a[0], 16'h0);

        // Single pulse on line 5
        pulse(0, 16'h0020);
        chk("p5_pending", 0, pend_a[0], 16'h0020);
        chk("p5_valid_early", 0, 16'(valid_a[0]), 16'h0);
        wait_valid(0, 10, n);
        chk("p5_latency", 0, 16'(n), 16'd1);
        chk("p5_id", 0, 16'(id_a[0]), 16'd5);
        do_ack(0);
        chk("p5_pending_cleared", 0, pend_a[0], 16'h0);
        repeat (4) tick();
        chk("p5_no_represent", 0, 16'(valid_a[0]), 16'h0);

        // Three lines rising together come out in priority order
        pulse(0, 16'h8011);
        wait_valid(0, 10, n);
        chk("ord_id0", 0, 16'(id_a[0]), 16'd0);
        do_ack(0);
        wait_valid(0, 10, n);
        chk("ord_gap1", 0, 16'(n), 16'd2);
        chk("ord_id4", 0, 16'(id_a[0]), 16'd4);
        do_ack(0);
        wait_valid(0, 10, n);
        chk("ord_gap2", 0, 16'(n), 16'd2);
        chk("ord_id15", 0, 16'(id_a[0]), 16'd15);
        do_ack(0);
        repeat (4) tick();
        chk("ord_idle", 0, 16'(valid_a[0]), 16'h0);

        // No preemption by a higher-priority arrival
        pulse(0, 16'h0080);
        wait_valid(0, 10, n);
        chk("pre_id7", 0, 16'(id_a[0]), 16'd7);
        pulse(0, 16'h0004);
        tick();
        chk("pre_id_held", 0, 16'(id_a[0]), 16'd7);
        do_ack(0);
        wait_valid(0, 10, n);
        chk("pre_id2", 0, 16'(id_a[0]), 16'd2);
        do_ack(0);
        repeat (3) tick();

        // Masked arrival waits until unmasked
        mask_a[0] = 16'h0004;
        pulse(0, 16'h0080);
        wait_valid(0, 10, n);
        chk("msk_id7", 0, 16'(id_a[0]), 16'd7);
        pulse(0, 16'h0004);
        do_ack(0);
        repeat (5) tick();
        chk("msk_quiet", 0, 16'(valid_a[0]), 16'h0);
        chk("msk_pending", 0, pend_a[0], 16'h0004);
        mask_a[0] = 16'h0;
        wait_valid(0, 10, n);
        chk("msk_id2", 0, 16'(id_a[0]), 16'd2);
        do_ack(0);
        repeat (3) tick();

        // Ack and a new rising edge on the same line at the same edge
        pulse(0, 16'h0008);
        wait_valid(0, 10, n);
        chk("col_id3", 0, 16'(id_a[0]), 16'd3);
        ack_a[0] = 1'b1;
        req_a[0] = 16'h0008;
        tick();
        ack_a[0] = 1'b0;
        req_a[0] = 16'h0;
        chk("col_pending", 0, pend_a[0], 16'h0008);
        chk("col_valid", 0, 16'(valid_a[0]), 16'h0);
        wait_valid(0, 10, n);
        chk("col_gap", 0, 16'(n), 16'd2);
        chk("col_id3_again", 0, 16'(id_a[0]), 16'd3);
        do_ack(0);
        repeat (2) tick();
        chk("col_pending_clear", 0, pend_a[0], 16'h0);

        // Line held through reset counts as an edge after release
        req_a[0] = 16'h0200;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_pending", 0, pend_a[0], 16'h0200);
        wait_valid(0, 10, n);
        chk("rst_id9", 0, 16'(id_a[0]), 16'd9);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 0, 16'(valid_a[0]), 16'h0);
        chk("async_pending", 0, pend_a[0], 16'h0);
        chk("async_id", 0, 16'(id_a[0]), 16'h0);
        req_a[0] = 16'h0;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Level mode with a 3-cycle hold-off
        req_a[1] = 16'h0002;
        wait_valid(1, 10, n);
        chk("lvl_id1", 1, 16'(id_a[1]), 16'd1);
        chk("lvl_pending", 1, pend_a[1], 16'h0002);
        do_ack(1);
        wait_valid(1, 20, n);
        chk("lvl_regap", 1, 16'(n), 16'd4);
        chk("lvl_id1_again", 1, 16'(id_a[1]), 16'd1);
        req_a[1] = 16'h0;
        do_ack(1);
        repeat (8) tick();
        chk("lvl_idle", 1, 16'(valid_a[1]), 16'h0);
        chk("lvl_pending_clear", 1, pend_a[1], 16'h0);

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                req_a[k] = 16'($urandom & $urandom & $urandom);
                if ($urandom_range(0, 15) == 0) mask_a[k] = 16'($urandom & $urandom);
                ack_a[k] = ($urandom_range(0, 2) == 0);
            end
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_a[k] = 16'h0;
            ack_a[k] = 1'b0;
        end
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
